imem_boot_loader: RTL and testbench

- Sits directly upstream of the instruction memory and holds the single-cycle processor in reset until a program image has been loaded.
- Accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port, verifies an 8-bit checksum, then releases the processor.

---
 rtl/imem_boot_loader.sv | 129 ++++++++++++
 tb/tb_imem_boot_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes big-endian words into
// instruction memory, verifies an 8-bit additive checksum, then releases the CPU.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_run,
    output logic        busy,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_PAYLOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] count_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  csum_reg;
    logic [31:0] asm_reg;

    logic        accept;
    logic        word_done;
    logic [15:0] n_full;
    logic        next_accepts;
    logic        next_busy;

    assign accept = rx_valid && rx_ready;
    assign n_full = {count_reg[15:8], rx_data};

    always_comb begin
        state_next = state_reg;
        word_done  = 1'b0;
        case (state_reg)
            S_CNT_HI: begin
                if (accept) state_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if ({16'd0, n_full} > 32'(MAX_WORDS))
                        state_next = S_ERROR;
                    else if (n_full == 16'd0)
                        state_next = S_CHECK;
                    else
                        state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept && byte_idx_reg == 2'd3) begin
                    word_done = 1'b1;
                    // The last word's pulse overlaps S_CHECK so the check byte can follow immediately.
                    if (words_loaded + 16'd1 == count_reg)
                        state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept)
                    state_next = (rx_data == csum_reg) ? S_RUN : S_ERROR;
            end
            default: state_next = state_reg;
        endcase
    end

    assign next_accepts = (state_next == S_CNT_HI) || (state_next == S_CNT_LO) ||
                          (state_next == S_PAYLOAD) || (state_next == S_CHECK);
    assign next_busy    = (state_next == S_CNT_LO) || (state_next == S_PAYLOAD) ||
                          (state_next == S_CHECK);

    always_ff @(posedge clk) begin
        if (!areset) begin
            state_reg    <= S_CNT_HI;
            count_reg    <= 16'd0;
            byte_idx_reg <= 2'd0;
            csum_reg     <= 8'd0;
            asm_reg      <= 32'd0;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wd      <= 32'd0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state_reg <= state_next;
            rx_ready  <= next_accepts;
            busy      <= next_busy;
            // cpu_run trails entry to S_RUN by one edge.
            cpu_run   <= (state_reg == S_RUN);
            err       <= err || (state_next == S_ERROR);
            imem_we   <= word_done;

            if (accept && state_reg != S_CHECK)
                csum_reg <= csum_reg + rx_data;

            if (accept && state_reg == S_CNT_HI)
                count_reg[15:8] <= rx_data;
            if (accept && state_reg == S_CNT_LO)
                count_reg[7:0] <= rx_data;

            if (accept && state_reg == S_PAYLOAD) begin
                asm_reg      <= {asm_reg[23:0], rx_data};
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end

            if (word_done) begin
                imem_wd      <= {asm_reg[23:0], rx_data};
                imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: byte-level image model derives every
// expected output from the accepted byte history; literal checks pin the scenarios.
module tb_imem_boot_loader;

    localparam int unsigned MAX_W = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    imem_boot_loader #(.MAX_WORDS(MAX_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .areset(areset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_run(cpu_run), .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: everything follows from the list of bytes accepted since reset.
    logic [7:0]  got[$];
    logic        m_ready, m_we, m_run, m_busy, m_err, m_term, ok_pending;
    logic [31:0] m_addr, m_wd;
    logic [15:0] m_words;

    logic [7:0]  img[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int n;
        int nw;
        int k;
        logic [7:0] s;
        if (!areset) begin
            got.delete();
            m_ready = 0; m_we = 0; m_run = 0; m_busy = 0; m_err = 0;
            m_term = 0; ok_pending = 0; m_addr = BASE; m_wd = 0; m_words = 0;
            return;
        end
        m_we  = 0;
        m_run = ok_pending;
        if (rx_valid && m_ready) begin
            got.push_back(rx_data);
            n  = got.size();
            nw = (n >= 2) ? int'({got[0], got[1]}) : 0;
            if (n == 2 && nw > int'(MAX_W)) begin
                m_err = 1; m_term = 1;
            end else if (n > 2 && n <= 2 + 4 * nw && (n - 2) % 4 == 0) begin
                k       = (n - 2) / 4;
                m_we    = 1;
                m_addr  = BASE + 32'(4 * (k - 1));
                m_wd    = {got[n-4], got[n-3], got[n-2], got[n-1]};
                m_words = 16'(k);
            end else if (n == 3 + 4 * nw) begin
                s = 8'd0;
                for (int j = 0; j < n - 1; j++) s = s + got[j];
                if (s == got[n-1]) ok_pending = 1;
                else               m_err = 1;
                m_term = 1;
            end
        end
        m_ready = !m_term;
        m_busy  = (got.size() > 0) && !m_term;
    endtask

    task automatic compare_all();
        chk("rx_ready", 32'(rx_ready), 32'(m_ready));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wd", imem_wd, m_wd);
        chk("cpu_run", 32'(cpu_run), 32'(m_run));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("err", 32'(err), 32'(m_err));
        chk("words_loaded", 32'(words_loaded), 32'(m_words));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wd);
        end
    endtask

    task automatic do_reset();
        areset   = 1'b0;
        rx_valid = 1'b0;
        step();
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wd", imem_wd, 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_ready", 32'(rx_ready), 32'd0);
        areset = 1'b1;
        step();
        chk("post_rst_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic send(input bit rnd);
        int  i    = 0;
        int  cyc  = 0;
        int  idle = 0;
        bit  acc;
        while (i < img.size() && idle < 4) begin
            if (cyc >= 4000) begin
                total++; bad++;
                $display("FAIL send_timeout: accepted %0d want %0d bytes", i, img.size());
                break;
            end
            rx_data  = img[i];
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc      = rx_valid && m_ready;
            step();
            cyc++;
            if (acc) i++;
            if (m_term) idle++;
        end
        rx_valid = 1'b0;
    endtask

    // Offer junk bytes once the loader is terminal; they must be ignored.
    task automatic settle(input int n);
        for (int c = 0; c < n; c++) begin
            rx_data  = 8'($urandom);
            rx_valid = m_term;
            step();
        end
        rx_valid = 1'b0;
    endtask

    task automatic build_image(input logic [31:0] words[$], input bit corrupt);
        logic [7:0] s;
        img = {8'(words.size() >> 8), 8'(words.size())};
        foreach (words[w]) begin
            img.push_back(words[w][31:24]);
            img.push_back(words[w][23:16]);
            img.push_back(words[w][15:8]);
            img.push_back(words[w][7:0]);
        end
        s = 8'd0;
        foreach (img[b]) s = s + img[b];
        img.push_back(corrupt ? s + 8'd1 : s);
    endtask

    task automatic report(input string tag);
        $display("image %s: bytes=%0d writes=%0d words_loaded=%0d cpu_run=%0d err=%0d",
                 tag, img.size(), wr_addr.size(), words_loaded, cpu_run, err);
    endtask

    initial begin
        logic [31:0] wq[$];
        areset   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        // One-word image, valid held high.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2E};
        send(1'b0);
        settle(3);
        report("one_word");
        chk("s1_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("s1_addr", wr_addr[0], 32'h0);
            chk("s1_data", wr_data[0], 32'h2008_0005);
        end
        chk("s1_words", 32'(words_loaded), 32'd1);
        chk("s1_run", 32'(cpu_run), 32'd1);
        chk("s1_err", 32'(err), 32'd0);

        // Three words, random valid.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        wq = {32'h2008_0005, 32'h2009_000A, 32'h0109_5020};
        build_image(wq, 1'b0);
        send(1'b1);
        settle(3);
        report("three_word");
        chk("s2_nwrites", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("s2_addr0", wr_addr[0], 32'h0);
            chk("s2_addr1", wr_addr[1], 32'h4);
            chk("s2_addr2", wr_addr[2], 32'h8);
            chk("s2_data0", wr_data[0], 32'h2008_0005);
            chk("s2_data1", wr_data[1], 32'h2009_000A);
            chk("s2_data2", wr_data[2], 32'h0109_5020);
        end
        chk("s2_run", 32'(cpu_run), 32'd1);

        // Bad check byte.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2F};
        send(1'b0);
        settle(4);
        report("bad_check");
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_run", 32'(cpu_run), 32'd0);
        chk("s3_ready", 32'(rx_ready), 32'd0);
        chk("s3_nwrites", 32'(wr_addr.size()), 32'd1);

        // Count above MAX_WORDS.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        img = {8'h01, 8'h01, 8'h11, 8'h22};
        send(1'b0);
        settle(3);
        report("too_many");
        chk("s4_err", 32'(err), 32'd1);
        chk("s4_nwrites", 32'(wr_addr.size()), 32'd0);
        chk("s4_busy", 32'(busy), 32'd0);

        // Empty image, good and bad check byte.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        img = {8'h00, 8'h00, 8'h00};
        send(1'b0);
        settle(3);
        report("empty_ok");
        chk("s5_run", 32'(cpu_run), 32'd1);
        chk("s5_nwrites", 32'(wr_addr.size()), 32'd0);
        do_reset();
        img = {8'h00, 8'h00, 8'h01};
        send(1'b0);
        settle(3);
        report("empty_bad");
        chk("s5b_err", 32'(err), 32'd1);
        chk("s5b_run", 32'(cpu_run), 32'd0);

        // Reset in the middle of a word, then a full reload.
        do_reset();
        wr_addr.delete(); wr_data.delete();
        img = {8'h00, 8'h01, 8'h20, 8'h08};
        send(1'b0);
        do_reset();
        img = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2E};
        send(1'b0);
        settle(3);
        report("mid_reset");
        chk("s6_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("s6_addr", wr_addr[0], 32'h0);
            chk("s6_data", wr_data[0], 32'h2008_0005);
        end
        chk("s6_run", 32'(cpu_run), 32'd1);

        // Randomized images, some with a corrupted checksum.
        for (int r = 0; r < 8; r++) begin
            int  n;
            bit  corrupt;
            n       = $urandom_range(0, 5);
            corrupt = ($urandom_range(0, 2) == 0);
            wq.delete();
            for (int w = 0; w < n; w++) wq.push_back($urandom);
            do_reset();
            wr_addr.delete(); wr_data.delete();
            build_image(wq, corrupt);
            send(1'b1);
            settle(3);
            report("random");
            chk("rnd_nwrites", 32'(wr_addr.size()), 32'(n));
            chk("rnd_err", 32'(err), 32'(corrupt));
            chk("rnd_run", 32'(cpu_run), 32'(!corrupt));
            for (int w = 0; w < n && w < wr_data.size(); w++) begin
                chk("rnd_addr", wr_addr[w], BASE + 32'(4 * w));
                chk("rnd_data", wr_data[w], wq[w]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
